collision_ctrl: RTL

//  Downstream consumer of the car lane movers: compares each lane's car column with the frog's grid cell.

---
 rtl/collision_pkg.sv | 22 ++
 rtl/collision_ctrl_lane_hit.sv | 18 +
 rtl/collision_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/collision_pkg.sv
// Shared grid geometry and collision FSM state encoding for the car lanes,
// collision controller and renderer.
package collision_pkg;

    localparam int unsigned GRID_COLS = 20;
    localparam int unsigned GRID_ROWS = 15;
    localparam int unsigned CAR_X_W   = 5;
    localparam int unsigned ROW_W     = 4;
    localparam int unsigned LEVEL_W   = 7;
    localparam int unsigned LIVES_W   = 3;
    localparam int unsigned HOLD_W    = 24;

    localparam logic [1:0] ST_PLAY      = 2'd0;
    localparam logic [1:0] ST_HIT_HOLD  = 2'd1;
    localparam logic [1:0] ST_GAME_OVER = 2'd2;

    typedef logic [CAR_X_W-1:0] car_x_t;
    typedef logic [ROW_W-1:0]   row_t;
    typedef logic [LEVEL_W-1:0] level_t;
    typedef logic [LIVES_W-1:0] lives_t;

endpackage

// File: rtl/collision_ctrl_lane_hit.sv
// Single-lane collision term: the frog is hit when it sits on this lane's row
// in exactly the car's column.
module lane_hit
    import collision_pkg::*;
#(
    parameter row_t LANE_ROW = '0
) (
    input  car_x_t i_frog_x,
    input  row_t   i_frog_y,
    input  car_x_t i_car_x,
    output logic   o_hit
);

    always_comb begin
        o_hit = (i_frog_y == LANE_ROW) && (i_car_x == i_frog_x);
    end

endmodule

// File: rtl/collision_ctrl.sv
// Collision, lives, hit-freeze, respawn and level control for the frog game.
// Optional build macro: INVINCIBLE_EN (hits still pulse and freeze, lives never drop).
module collision_ctrl
    import collision_pkg::*;
#(
    parameter int unsigned         NUM_LANES      = 4,
    parameter row_t                FIRST_LANE_ROW = 4'd2,
    parameter row_t                GOAL_ROW       = 4'd0,
    parameter lives_t              INIT_LIVES     = 3'd3,
    parameter level_t              MAX_LEVEL      = 7'd16,
    parameter logic [HOLD_W-1:0]   HOLD_CYCLES    = 24'd12_500_000
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic [CAR_X_W-1:0]             i_frog_x,
    input  logic [ROW_W-1:0]               i_frog_y,
    input  logic [CAR_X_W*NUM_LANES-1:0]   i_car_x,
    input  logic                           i_start,
    output logic [LEVEL_W-1:0]             o_level,
    output logic [LIVES_W-1:0]             o_lives,
    output logic                           o_hit,
    output logic                           o_respawn,
    output logic                           o_level_up,
    output logic                           o_freeze,
    output logic                           o_game_over
);

    logic [NUM_LANES-1:0] lane_hits;
    logic                 any_hit;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        lane_hit #(
            .LANE_ROW (FIRST_LANE_ROW + ROW_W'(k))
        ) u_lane_hit (
            .i_frog_x (i_frog_x),
            .i_frog_y (i_frog_y),
            .i_car_x  (i_car_x[CAR_X_W*k +: CAR_X_W]),
            .o_hit    (lane_hits[k])
        );
    end

    assign any_hit = |lane_hits;

    logic [1:0]        state_q, state_d;
    lives_t            lives_q, lives_d;
    level_t            level_q, level_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              hit_q, hit_d;
    logic              respawn_q, respawn_d;
    logic              level_up_q, level_up_d;
    logic              freeze_q, freeze_d;
    logic              game_over_q, game_over_d;

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        level_d    = level_q;
        hold_d     = hold_q;
        hit_d      = 1'b0;
        respawn_d  = 1'b0;
        level_up_d = 1'b0;

        case (state_q)
            ST_PLAY: begin
                if (any_hit) begin
                    hit_d = 1'b1;
`ifdef INVINCIBLE_EN
                    state_d = ST_HIT_HOLD;
                    hold_d  = HOLD_CYCLES;
`else
                    if (lives_q <= LIVES_W'(1)) begin
                        lives_d = '0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d = lives_q - LIVES_W'(1);
                        state_d = ST_HIT_HOLD;
                        hold_d  = HOLD_CYCLES;
                    end
`endif
                end else if (i_frog_y == GOAL_ROW) begin
                    level_up_d = 1'b1;
                    respawn_d  = 1'b1;
                    if (level_q < MAX_LEVEL) begin
                        level_d = level_q + LEVEL_W'(1);
                    end
                end
            end
            ST_HIT_HOLD: begin
                // Collisions are masked here, so a car parked on the frog
                // counts once per hold window.
                if (hold_q == '0) begin
                    respawn_d = 1'b1;
                    state_d   = ST_PLAY;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            ST_GAME_OVER: begin
                lives_d = '0;
                if (i_start) begin
                    lives_d   = INIT_LIVES;
                    level_d   = LEVEL_W'(1);
                    respawn_d = 1'b1;
                    state_d   = ST_PLAY;
                end
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase

        freeze_d    = (state_d != ST_PLAY);
        game_over_d = (state_d == ST_GAME_OVER);
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= ST_PLAY;
            lives_q     <= INIT_LIVES;
            level_q     <= LEVEL_W'(1);
            hold_q      <= '0;
            hit_q       <= 1'b0;
            respawn_q   <= 1'b0;
            level_up_q  <= 1'b0;
            freeze_q    <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            hold_q      <= hold_d;
            hit_q       <= hit_d;
            respawn_q   <= respawn_d;
            level_up_q  <= level_up_d;
            freeze_q    <= freeze_d;
            game_over_q <= game_over_d;
        end
    end

    assign o_level     = level_q;
    assign o_lives     = lives_q;
    assign o_hit       = hit_q;
    assign o_respawn   = respawn_q;
    assign o_level_up  = level_up_q;
    assign o_freeze    = freeze_q;
    assign o_game_over = game_over_q;

endmodule
